// File: rtl/tictactoe_game_ctrl.sv
// tictactoe_game_ctrl
//   Game-control stage feeding the VGA painter / colour-config block.
//   Debounces five raw push-buttons, moves a cursor over the 3x3 board,
//   stores the marks, alternates turns and detects a win or a tie.
//
// Ports
//   clk_100MHz                 system clock (single domain)
//   rst                        synchronous, active-high reset
//   btn_up/down/left/right/sel raw asynchronous buttons, active-high
//   up/down/left/right         debounced one-cycle press pulses
//   xm, ym                     top-left pixel of the cursor cell (registered)
//   board                      cell k = r*3+c at [2k+1:2k]; 00 empty, 01 X, 10 O
//   turn_o                     0 = X to move, 1 = O to move
//   ceSS, cePS, ceWSX, ceWSO, ceT  one-hot screen enables
module tictactoe_game_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 2_000_000,
  parameter int unsigned GRID_X0         = 170,
  parameter int unsigned GRID_Y0         = 90,
  parameter int unsigned CELL_SIZE       = 100
) (
  input  logic        clk_100MHz,
  input  logic        rst,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_sel,
  output logic        up,
  output logic        down,
  output logic        left,
  output logic        right,
  output logic [9:0]  xm,
  output logic [9:0]  ym,
  output logic [17:0] board,
  output logic        turn_o,
  output logic        ceSS,
  output logic        cePS,
  output logic        ceWSX,
  output logic        ceWSO,
  output logic        ceT
);

  localparam int unsigned NB = 5;
  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  // Button index: 0 up, 1 down, 2 left, 3 right, 4 sel
  logic [NB-1:0] raw, sync1, sync2, level, pulse;
  logic [CW-1:0] cnt [NB];

  assign raw = {btn_sel, btn_right, btn_left, btn_down, btn_up};

  // The counter only runs while the synchronised sample differs from the
  // debounced level; any return to the old level reloads it, so a bounce
  // shorter than DEBOUNCE_CYCLES never reaches the update.
  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      level <= '0;
      pulse <= '0;
      for (int unsigned i = 0; i < NB; i++) cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int unsigned i = 0; i < NB; i++) begin
        pulse[i] <= 1'b0;
        if (sync2[i] == level[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          cnt[i]   <= '0;
          level[i] <= sync2[i];
          pulse[i] <= sync2[i];
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign up    = pulse[0];
  assign down  = pulse[1];
  assign left  = pulse[2];
  assign right = pulse[3];

  // One action per cycle: sel > up > down > left > right
  logic act_sel, act_up, act_down, act_left, act_right;
  assign act_sel   = pulse[4];
  assign act_up    = pulse[0] & ~pulse[4];
  assign act_down  = pulse[1] & ~|{pulse[4], pulse[0]};
  assign act_left  = pulse[2] & ~|{pulse[4], pulse[0], pulse[1]};
  assign act_right = pulse[3] & ~|{pulse[4], pulse[0], pulse[1], pulse[2]};

  typedef enum logic [2:0] {
    S_START, S_PLAY, S_CHECK, S_WIN_X, S_WIN_O, S_TIE
  } state_t;

  state_t      state, state_next;
  logic [1:0]  row, col, row_next, col_next;
  logic [17:0] board_next;
  logic        turn_next;
  logic [3:0]  cell_idx;
  logic [17:0] cell_mask, place_mask;
  logic        occupied, line_win, board_full;

  function automatic logic has_line(input logic [17:0] b, input logic [1:0] m);
    logic [8:0] own;
    for (int unsigned k = 0; k < 9; k++) own[k] = (b[2*k +: 2] == m);
    return (own[0] & own[1] & own[2]) | (own[3] & own[4] & own[5]) |
           (own[6] & own[7] & own[8]) | (own[0] & own[3] & own[6]) |
           (own[1] & own[4] & own[7]) | (own[2] & own[5] & own[8]) |
           (own[0] & own[4] & own[8]) | (own[2] & own[4] & own[6]);
  endfunction

  function automatic logic all_filled(input logic [17:0] b);
    logic f;
    f = 1'b1;
    for (int unsigned k = 0; k < 9; k++) f = f & (b[2*k +: 2] != 2'b00);
    return f;
  endfunction

  function automatic logic [9:0] pos(input logic [1:0] idx, input int unsigned base);
    case (idx)
      2'd0:    return 10'(base);
      2'd1:    return 10'(base + CELL_SIZE);
      default: return 10'(base + 2 * CELL_SIZE);
    endcase
  endfunction

  assign cell_idx   = 4'({row, 1'b0}) + 4'(row) + 4'(col);
  assign cell_mask  = 18'(2'b11) << {cell_idx, 1'b0};
  assign place_mask = 18'(turn_o ? 2'b10 : 2'b01) << {cell_idx, 1'b0};
  assign occupied   = |(board & cell_mask);
  // In CHECK the board already holds the mark of the player still in turn_o.
  assign line_win   = has_line(board, turn_o ? 2'b10 : 2'b01);
  assign board_full = all_filled(board);

  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      state  <= S_START;
      board  <= '0;
      turn_o <= 1'b0;
      row    <= 2'd1;
      col    <= 2'd1;
      xm     <= pos(2'd1, GRID_X0);
      ym     <= pos(2'd1, GRID_Y0);
    end else begin
      state  <= state_next;
      board  <= board_next;
      turn_o <= turn_next;
      row    <= row_next;
      col    <= col_next;
      xm     <= pos(col_next, GRID_X0);
      ym     <= pos(row_next, GRID_Y0);
    end
  end

  always_comb begin
    state_next = state;
    board_next = board;
    turn_next  = turn_o;
    row_next   = row;
    col_next   = col;
    ceSS       = 1'b0;
    cePS       = 1'b0;
    ceWSX      = 1'b0;
    ceWSO      = 1'b0;
    ceT        = 1'b0;
    case (state)
      S_START: begin
        ceSS = 1'b1;
        if (act_sel) state_next = S_PLAY;
      end
      S_PLAY: begin
        cePS = 1'b1;
        if (act_sel) begin
          if (!occupied) begin
            board_next = board | place_mask;
            state_next = S_CHECK;
          end
        end else if (act_up && row != 2'd0) begin
          row_next = row - 2'd1;
        end else if (act_down && row != 2'd2) begin
          row_next = row + 2'd1;
        end else if (act_left && col != 2'd0) begin
          col_next = col - 2'd1;
        end else if (act_right && col != 2'd2) begin
          col_next = col + 2'd1;
        end
      end
      S_CHECK: begin
        cePS = 1'b1;
        if (line_win) begin
          state_next = turn_o ? S_WIN_O : S_WIN_X;
        end else if (board_full) begin
          state_next = S_TIE;
        end else begin
          turn_next  = ~turn_o;
          state_next = S_PLAY;
        end
      end
      S_WIN_X, S_WIN_O, S_TIE: begin
        ceWSX = (state == S_WIN_X);
        ceWSO = (state == S_WIN_O);
        ceT   = (state == S_TIE);
        if (act_sel) begin
          state_next = S_START;
          board_next = '0;
          turn_next  = 1'b0;
          row_next   = 2'd1;
          col_next   = 2'd1;
        end
      end
      default: begin
        state_next = S_START;
      end
    endcase
  end

endmodule

// File: tb/tb_tictactoe_game_ctrl.sv
module tb_tictactoe_game_ctrl;

  logic        clk_100MHz = 1'b0;
  logic        rst = 1'b1;
  logic        btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0, btn_sel = 1'b0;
  logic        up, down, left, right;
  logic [9:0]  xm, ym;
  logic [17:0] board;
  logic        turn_o;
  logic        ceSS, cePS, ceWSX, ceWSO, ceT;

  always #5 clk_100MHz = ~clk_100MHz;

  tictactoe_game_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .GRID_X0(170),
    .GRID_Y0(90),
    .CELL_SIZE(100)
  ) dut (
    .clk_100MHz(clk_100MHz),
    .rst(rst),
    .btn_up(btn_up),
    .btn_down(btn_down),
    .btn_left(btn_left),
    .btn_right(btn_right),
    .btn_sel(btn_sel),
    .up(up),
    .down(down),
    .left(left),
    .right(right),
    .xm(xm),
    .ym(ym),
    .board(board),
    .turn_o(turn_o),
    .ceSS(ceSS),
    .cePS(cePS),
    .ceWSX(ceWSX),
    .ceWSO(ceWSO),
    .ceT(ceT)
  );

  // Buttons: [0] up [1] down [2] left [3] right [4] sel
  localparam logic [4:0] B_UP = 5'b00001, B_DN = 5'b00010, B_LT = 5'b00100,
                         B_RT = 5'b01000, B_SEL = 5'b10000;
  // Enables packed as {ceSS, cePS, ceWSX, ceWSO, ceT}
  localparam logic [4:0] E_SS = 5'b10000, E_PS = 5'b01000, E_WX = 5'b00100,
                         E_WO = 5'b00010, E_T = 5'b00001;

  typedef struct {
    logic [4:0]  btn;
    logic [9:0]  xm;
    logic [9:0]  ym;
    logic [17:0] board;
    logic        turn;
    logic [4:0]  ce;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];

  int unsigned n_tests = 0, n_fail = 0;
  int unsigned cnt_up = 0, cnt_down = 0, cnt_left = 0, cnt_right = 0;

  always @(negedge clk_100MHz) begin
    if (up)    cnt_up++;
    if (down)  cnt_down++;
    if (left)  cnt_left++;
    if (right) cnt_right++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [4:0] ce_bus();
    return {ceSS, cePS, ceWSX, ceWSO, ceT};
  endfunction

  function automatic vec_t mk(input logic [4:0] b, input int unsigned x, input int unsigned y,
                              input logic [17:0] bd, input logic t, input logic [4:0] ce);
    vec_t v;
    v.btn = b; v.xm = 10'(x); v.ym = 10'(y); v.board = bd; v.turn = t; v.ce = ce;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] b);
    btn_up = b[0]; btn_down = b[1]; btn_left = b[2]; btn_right = b[3]; btn_sel = b[4];
  endtask

  task automatic press(input logic [4:0] b);
    @(negedge clk_100MHz);
    drive(b);
    repeat (6) @(negedge clk_100MHz);
    drive(5'b0);
    repeat (8) @(negedge clk_100MHz);
  endtask

  task automatic run_vec(input int unsigned idx, input vec_t v);
    vec_t e;
    int unsigned u0, d0, l0, r0;
    logic [31:0] dp, ep;
    u0 = cnt_up; d0 = cnt_down; l0 = cnt_left; r0 = cnt_right;
    exp_q.push_back(v);
    press(v.btn);
    e = exp_q.pop_front();
    check($sformatf("v%0d_xm", idx), 32'(xm), 32'(e.xm));
    check($sformatf("v%0d_ym", idx), 32'(ym), 32'(e.ym));
    check($sformatf("v%0d_board", idx), 32'(board), 32'(e.board));
    check($sformatf("v%0d_turn", idx), 32'(turn_o), 32'(e.turn));
    check($sformatf("v%0d_ce", idx), 32'(ce_bus()), 32'(e.ce));
    dp = {8'(cnt_up - u0), 8'(cnt_down - d0), 8'(cnt_left - l0), 8'(cnt_right - r0)};
    ep = {8'(e.btn[0]), 8'(e.btn[1]), 8'(e.btn[2]), 8'(e.btn[3])};
    check($sformatf("v%0d_pulses", idx), dp, ep);
  endtask

  // sel pressed together with one arrow: arrow pulse marks cycle N of the sel pulse
  task automatic combo(input string tag, input logic [4:0] b, input logic [17:0] exp_board,
                       input int unsigned exp_xm, input int unsigned exp_ym,
                       input logic [4:0] exp_ce, input logic exp_turn);
    logic seen;
    logic [17:0] b0;
    b0 = board;
    @(negedge clk_100MHz);
    drive(b);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk_100MHz);
      if ((b[0] & up) | (b[2] & left)) seen = 1'b1;
    end
    check({tag, "_pulse_seen"}, 32'(seen), 32'd1);
    check({tag, "_board_N"}, 32'(board), 32'(b0));
    @(negedge clk_100MHz);
    check({tag, "_board_N1"}, 32'(board), 32'(exp_board));
    check({tag, "_ce_N1"}, 32'(ce_bus()), 32'(E_PS));
    check({tag, "_xm_N1"}, 32'(xm), exp_xm);
    @(negedge clk_100MHz);
    check({tag, "_ce_N2"}, 32'(ce_bus()), 32'(exp_ce));
    check({tag, "_xm_N2"}, 32'(xm), exp_xm);
    check({tag, "_ym_N2"}, 32'(ym), exp_ym);
    check({tag, "_turn_N2"}, 32'(turn_o), 32'(exp_turn));
    drive(5'b0);
    repeat (10) @(negedge clk_100MHz);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ce"}, 32'(ce_bus()), 32'(E_SS));
    check({tag, "_board"}, 32'(board), 32'd0);
    check({tag, "_xm"}, 32'(xm), 32'd270);
    check({tag, "_ym"}, 32'(ym), 32'd190);
    check({tag, "_turn"}, 32'(turn_o), 32'd0);
    check({tag, "_pulses"}, 32'({up, down, left, right}), 32'd0);
  endtask

  initial begin
    int unsigned r0;

    // Game A: cursor saturation, then X wins on the top row
    tbl.push_back(mk(B_SEL, 270, 190, 18'h00000, 1'b0, E_PS));
    tbl.push_back(mk(B_RT,  370, 190, 18'h00000, 1'b0, E_PS));
    tbl.push_back(mk(B_RT,  370, 190, 18'h00000, 1'b0, E_PS));
    tbl.push_back(mk(B_RT,  370, 190, 18'h00000, 1'b0, E_PS));
    tbl.push_back(mk(B_UP,  370,  90, 18'h00000, 1'b0, E_PS));
    tbl.push_back(mk(B_UP,  370,  90, 18'h00000, 1'b0, E_PS));
    tbl.push_back(mk(B_UP,  370,  90, 18'h00000, 1'b0, E_PS));
    tbl.push_back(mk(B_LT,  270,  90, 18'h00000, 1'b0, E_PS));
    tbl.push_back(mk(B_LT,  170,  90, 18'h00000, 1'b0, E_PS));
    tbl.push_back(mk(B_SEL, 170,  90, 18'h00001, 1'b1, E_PS));
    tbl.push_back(mk(B_DN,  170, 190, 18'h00001, 1'b1, E_PS));
    tbl.push_back(mk(B_SEL, 170, 190, 18'h00081, 1'b0, E_PS));
    tbl.push_back(mk(B_UP,  170,  90, 18'h00081, 1'b0, E_PS));
    tbl.push_back(mk(B_RT,  270,  90, 18'h00081, 1'b0, E_PS));
    tbl.push_back(mk(B_SEL, 270,  90, 18'h00085, 1'b1, E_PS));
    tbl.push_back(mk(B_DN,  270, 190, 18'h00085, 1'b1, E_PS));
    tbl.push_back(mk(B_SEL, 270, 190, 18'h00285, 1'b0, E_PS));
    tbl.push_back(mk(B_UP,  270,  90, 18'h00285, 1'b0, E_PS));
    tbl.push_back(mk(B_RT,  370,  90, 18'h00285, 1'b0, E_PS));
    // index 19..: after the winning move
    tbl.push_back(mk(B_RT,  370,  90, 18'h00295, 1'b0, E_WX));
    tbl.push_back(mk(B_SEL, 270, 190, 18'h00000, 1'b0, E_SS));
    // Game B: full board, no line
    tbl.push_back(mk(B_SEL, 270, 190, 18'h00000, 1'b0, E_PS));
    tbl.push_back(mk(B_UP,  270,  90, 18'h00000, 1'b0, E_PS));
    tbl.push_back(mk(B_LT,  170,  90, 18'h00000, 1'b0, E_PS));
    tbl.push_back(mk(B_SEL, 170,  90, 18'h00001, 1'b1, E_PS));
    tbl.push_back(mk(B_RT,  270,  90, 18'h00001, 1'b1, E_PS));
    tbl.push_back(mk(B_SEL, 270,  90, 18'h00009, 1'b0, E_PS));
    tbl.push_back(mk(B_RT,  370,  90, 18'h00009, 1'b0, E_PS));
    tbl.push_back(mk(B_SEL, 370,  90, 18'h00019, 1'b1, E_PS));
    tbl.push_back(mk(B_DN,  370, 190, 18'h00019, 1'b1, E_PS));
    tbl.push_back(mk(B_LT,  270, 190, 18'h00019, 1'b1, E_PS));
    tbl.push_back(mk(B_SEL, 270, 190, 18'h00219, 1'b0, E_PS));
    tbl.push_back(mk(B_LT,  170, 190, 18'h00219, 1'b0, E_PS));
    tbl.push_back(mk(B_SEL, 170, 190, 18'h00259, 1'b1, E_PS));
    tbl.push_back(mk(B_RT,  270, 190, 18'h00259, 1'b1, E_PS));
    tbl.push_back(mk(B_RT,  370, 190, 18'h00259, 1'b1, E_PS));
    tbl.push_back(mk(B_SEL, 370, 190, 18'h00A59, 1'b0, E_PS));
    tbl.push_back(mk(B_DN,  370, 290, 18'h00A59, 1'b0, E_PS));
    tbl.push_back(mk(B_LT,  270, 290, 18'h00A59, 1'b0, E_PS));
    tbl.push_back(mk(B_SEL, 270, 290, 18'h04A59, 1'b1, E_PS));
    tbl.push_back(mk(B_LT,  170, 290, 18'h04A59, 1'b1, E_PS));
    tbl.push_back(mk(B_SEL, 170, 290, 18'h06A59, 1'b0, E_PS));
    tbl.push_back(mk(B_RT,  270, 290, 18'h06A59, 1'b0, E_PS));
    tbl.push_back(mk(B_RT,  370, 290, 18'h06A59, 1'b0, E_PS));
    tbl.push_back(mk(B_SEL, 370, 290, 18'h16A59, 1'b0, E_T));
    tbl.push_back(mk(B_SEL, 270, 190, 18'h00000, 1'b0, E_SS));
    // Game C: occupied-cell select is ignored
    tbl.push_back(mk(B_SEL, 270, 190, 18'h00000, 1'b0, E_PS));
    tbl.push_back(mk(B_SEL, 270, 190, 18'h00100, 1'b1, E_PS));
    tbl.push_back(mk(B_SEL, 270, 190, 18'h00100, 1'b1, E_PS));
    tbl.push_back(mk(B_UP,  270,  90, 18'h00100, 1'b1, E_PS));

    // Reset state
    drive(5'b0);
    rst = 1'b1;
    repeat (3) @(negedge clk_100MHz);
    check_reset("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk_100MHz);

    // Short bounce gives no pulse; a long hold gives exactly one 1-cycle pulse
    r0 = cnt_right;
    drive(B_RT);
    repeat (3) @(negedge clk_100MHz);
    drive(5'b0);
    repeat (10) @(negedge clk_100MHz);
    check("bounce_no_pulse", 32'(cnt_right - r0), 32'd0);
    r0 = cnt_right;
    drive(B_RT);
    repeat (14) @(negedge clk_100MHz);
    drive(5'b0);
    repeat (10) @(negedge clk_100MHz);
    check("hold_one_pulse", 32'(cnt_right - r0), 32'd1);
    check("start_ignores_arrow", 32'({xm, ce_bus()}), 32'({10'd270, E_SS}));

    for (int unsigned i = 0; i < 19; i++) run_vec(i, tbl[i]);
    combo("win_x", B_SEL | B_UP, 18'h00295, 370, 90, E_WX, 1'b0);
    check("win_row0_bits", 32'(board[5:0]), 32'(6'b010101));
    for (int unsigned i = 19; i < 50; i++) run_vec(i, tbl[i]);
    combo("sel_left", B_SEL | B_LT, 18'h00108, 270, 90, E_PS, 1'b0);

    // Reset mid-game, landing on the edge where a right pulse was due
    @(negedge clk_100MHz);
    drive(B_RT);
    repeat (5) @(negedge clk_100MHz);
    r0 = cnt_right;
    rst = 1'b1;
    drive(5'b0);
    @(negedge clk_100MHz);
    check_reset("midreset");
    rst = 1'b0;
    repeat (12) @(negedge clk_100MHz);
    check("midreset_no_late_pulse", 32'(cnt_right - r0), 32'd0);
    check("midreset_still_start", 32'(ce_bus()), 32'(E_SS));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
